// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions.
// Provides the word and register-file sizes and a one-hot test helper used by
// the register bank and its select decoders.
package cpu_pkg;

   localparam int WORD_WIDTH = 32;
   localparam int NUM_REGS   = 16;
   localparam int REG_IDX_W  = 4;

   // True when exactly one bit of the vector is set.
   function automatic logic is_onehot(input logic [NUM_REGS-1:0] vec);
      return (vec != '0) && ((vec & (vec - NUM_REGS'(1))) == '0);
   endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot to binary decoder for register select enables.
// Ports:
//   sel   in  NUM_REGS   select vector (expected one-hot)
//   idx   out REG_IDX_W  binary index of the set bit, 0 unless valid
//   valid out 1          exactly one bit of sel is set
//   multi out 1          two or more bits of sel are set
module onehot_to_bin
   import cpu_pkg::*;
(
   input  logic [NUM_REGS-1:0]  sel,
   output logic [REG_IDX_W-1:0] idx,
   output logic                 valid,
   output logic                 multi
);

   logic [REG_IDX_W-1:0] idx_or;

   assign valid = is_onehot(sel);
   assign multi = (sel != '0) && !valid;

   // OR of the indices of every set bit; only meaningful when one bit is set.
   always_comb begin
      idx_or = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (sel[i]) idx_or = idx_or | REG_IDX_W'(i);
      end
   end

   assign idx = valid ? idx_or : '0;

endmodule

// File: rtl/gp_register_bank.sv
// General-purpose register bank for the CPU datapath.
// Stores NREGS x WIDTH registers written from the bus by one-hot Rin enables
// and read combinationally by one-hot Rout enables. R0 reads as zero while
// BAout is high. Malformed (multi-hot) enables raise sticky error flags.
// Ports:
//   clock        in   rising-edge clock
//   clear        in   asynchronous active-low reset
//   RinSignals   in   one-hot write enable
//   RoutSignals  in   one-hot read enable
//   BAout        in   base-address read, masks R0 to zero on the read path
//   BusMuxOut    in   write data
//   err_clr      in   synchronous clear of wr_err / rd_err
//   BusMuxIn_R   out  read data of the selected register
//   rout_idx     out  binary index of the selected read register
//   rout_valid   out  RoutSignals is one-hot
//   wr_err       out  sticky multi-hot write enable flag
//   rd_err       out  sticky multi-hot read enable flag
module gp_register_bank
   import cpu_pkg::*;
#(
   parameter int WIDTH = WORD_WIDTH,
   parameter int NREGS = NUM_REGS
) (
   input  logic                 clock,
   input  logic                 clear,
   input  logic [NREGS-1:0]     RinSignals,
   input  logic [NREGS-1:0]     RoutSignals,
   input  logic                 BAout,
   input  logic [WIDTH-1:0]     BusMuxOut,
   input  logic                 err_clr,
   output logic [WIDTH-1:0]     BusMuxIn_R,
   output logic [REG_IDX_W-1:0] rout_idx,
   output logic                 rout_valid,
   output logic                 wr_err,
   output logic                 rd_err
);

   logic [WIDTH-1:0]     regs [NREGS];
   logic [REG_IDX_W-1:0] wr_idx;
   logic                 wr_valid;
   logic                 wr_multi;
   logic [REG_IDX_W-1:0] rd_idx;
   logic                 rd_valid;
   logic                 rd_multi;

   onehot_to_bin u_rin_dec (
      .sel   (RinSignals),
      .idx   (wr_idx),
      .valid (wr_valid),
      .multi (wr_multi)
   );

   onehot_to_bin u_rout_dec (
      .sel   (RoutSignals),
      .idx   (rd_idx),
      .valid (rd_valid),
      .multi (rd_multi)
   );

   // A multi-hot Rin performs no write at all, so only wr_valid gates it.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wr_valid) begin
         regs[wr_idx] <= BusMuxOut;
      end
   end

   // Set has priority over err_clr so a violation in the clearing cycle is kept.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         wr_err <= 1'b0;
         rd_err <= 1'b0;
      end else begin
         if (wr_multi)     wr_err <= 1'b1;
         else if (err_clr) wr_err <= 1'b0;
         if (rd_multi)     rd_err <= 1'b1;
         else if (err_clr) rd_err <= 1'b0;
      end
   end

   // R0 is a real register; only its read value is masked under BAout.
   always_comb begin
      BusMuxIn_R = '0;
      if (rd_valid && !(BAout && (rd_idx == '0))) BusMuxIn_R = regs[rd_idx];
   end

   assign rout_idx   = rd_idx;
   assign rout_valid = rd_valid;

endmodule

// File: tb/tb_gp_register_bank.sv
module tb_gp_register_bank;

   logic        clock;
   logic        clear;
   logic [15:0] RinSignals;
   logic [15:0] RoutSignals;
   logic        BAout;
   logic [31:0] BusMuxOut;
   logic        err_clr;
   logic [31:0] BusMuxIn_R;
   logic [3:0]  rout_idx;
   logic        rout_valid;
   logic        wr_err;
   logic        rd_err;

   int n_cmp = 0;
   int n_bad = 0;

   gp_register_bank dut (
      .clock       (clock),
      .clear       (clear),
      .RinSignals  (RinSignals),
      .RoutSignals (RoutSignals),
      .BAout       (BAout),
      .BusMuxOut   (BusMuxOut),
      .err_clr     (err_clr),
      .BusMuxIn_R  (BusMuxIn_R),
      .rout_idx    (rout_idx),
      .rout_valid  (rout_valid),
      .wr_err      (wr_err),
      .rd_err      (rd_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      logic [15:0] sel;
      clear = 1'b0; RinSignals = '0; RoutSignals = '0; BAout = 1'b0;
      BusMuxOut = '0; err_clr = 1'b0;
      tick(); tick();
      clear = 1'b1;
      for (int i = 0; i < 16; i++) begin
         sel = 16'h0001 << i;
         RoutSignals = sel;
         #1;
         n_cmp++;
         if (BusMuxIn_R !== 32'h0) begin
            n_bad++; $display("FAIL reset_read R%0d: got %h expected 00000000", i, BusMuxIn_R);
         end
         n_cmp++;
         if (rout_idx !== 4'(i) || rout_valid !== 1'b1) begin
            n_bad++; $display("FAIL reset_idx R%0d: got idx %0d valid %b expected idx %0d valid 1", i, rout_idx, rout_valid, i);
         end
      end
      n_cmp++;
      if (wr_err !== 1'b0 || rd_err !== 1'b0) begin
         n_bad++; $display("FAIL reset_flags: got wr_err %b rd_err %b expected 0 0", wr_err, rd_err);
      end
      RoutSignals = '0;
      #1;
      n_cmp++;
      if (BusMuxIn_R !== 32'h0 || rout_idx !== 4'd0 || rout_valid !== 1'b0) begin
         n_bad++; $display("FAIL no_sel_read: got %h idx %0d valid %b expected 0 0 0", BusMuxIn_R, rout_idx, rout_valid);
      end
   endtask

   task automatic test_write_read();
      RinSignals = 16'h0020; BusMuxOut = 32'hDEADBEEF;
      tick();
      RinSignals = '0; BusMuxOut = 32'h0; RoutSignals = 16'h0020;
      #1;
      n_cmp++;
      if (BusMuxIn_R !== 32'hDEADBEEF || rout_idx !== 4'd5 || rout_valid !== 1'b1) begin
         n_bad++; $display("FAIL write_r5: got %h idx %0d valid %b expected deadbeef 5 1", BusMuxIn_R, rout_idx, rout_valid);
      end
      RoutSignals = 16'h0040;
      #1;
      n_cmp++;
      if (BusMuxIn_R !== 32'h0) begin
         n_bad++; $display("FAIL r6_untouched: got %h expected 00000000", BusMuxIn_R);
      end
      RoutSignals = '0;
   endtask

   task automatic test_r0_baout();
      RinSignals = 16'h0001; BusMuxOut = 32'h0000_1234;
      tick();
      RinSignals = '0; RoutSignals = 16'h0001; BAout = 1'b0;
      #1;
      n_cmp++;
      if (BusMuxIn_R !== 32'h0000_1234) begin
         n_bad++; $display("FAIL r0_read: got %h expected 00001234", BusMuxIn_R);
      end
      BAout = 1'b1;
      #1;
      n_cmp++;
      if (BusMuxIn_R !== 32'h0 || rout_valid !== 1'b1 || rout_idx !== 4'd0) begin
         n_bad++; $display("FAIL r0_baout: got %h idx %0d valid %b expected 0 0 1", BusMuxIn_R, rout_idx, rout_valid);
      end
      RoutSignals = 16'h0020;
      #1;
      n_cmp++;
      if (BusMuxIn_R !== 32'hDEADBEEF) begin
         n_bad++; $display("FAIL r5_baout: got %h expected deadbeef", BusMuxIn_R);
      end
      BAout = 1'b0; RoutSignals = '0;
   endtask

   task automatic test_wr_multi();
      RinSignals = 16'h0003; BusMuxOut = 32'hFFFF_FFFF;
      #1;
      n_cmp++;
      if (wr_err !== 1'b0) begin
         n_bad++; $display("FAIL wr_err_early: got %b expected 0", wr_err);
      end
      tick();
      RinSignals = '0; BusMuxOut = '0;
      n_cmp++;
      if (wr_err !== 1'b1) begin
         n_bad++; $display("FAIL wr_err_set: got %b expected 1", wr_err);
      end
      RoutSignals = 16'h0001;
      #1;
      n_cmp++;
      if (BusMuxIn_R !== 32'h0000_1234) begin
         n_bad++; $display("FAIL multi_r0_kept: got %h expected 00001234", BusMuxIn_R);
      end
      RoutSignals = 16'h0002;
      #1;
      n_cmp++;
      if (BusMuxIn_R !== 32'h0) begin
         n_bad++; $display("FAIL multi_r1_kept: got %h expected 00000000", BusMuxIn_R);
      end
      RoutSignals = '0;
      tick();
      n_cmp++;
      if (wr_err !== 1'b1) begin
         n_bad++; $display("FAIL wr_err_sticky: got %b expected 1", wr_err);
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      n_cmp++;
      if (wr_err !== 1'b0) begin
         n_bad++; $display("FAIL wr_err_clr: got %b expected 0", wr_err);
      end
   endtask

   task automatic test_rd_multi();
      RoutSignals = 16'h8001;
      #1;
      n_cmp++;
      if (BusMuxIn_R !== 32'h0 || rout_valid !== 1'b0 || rout_idx !== 4'd0 || rd_err !== 1'b0) begin
         n_bad++; $display("FAIL rd_multi_comb: got %h idx %0d valid %b rd_err %b expected 0 0 0 0", BusMuxIn_R, rout_idx, rout_valid, rd_err);
      end
      tick();
      n_cmp++;
      if (rd_err !== 1'b1 || wr_err !== 1'b0) begin
         n_bad++; $display("FAIL rd_err_set: got rd_err %b wr_err %b expected 1 0", rd_err, wr_err);
      end
      err_clr = 1'b1;
      tick();
      n_cmp++;
      if (rd_err !== 1'b1) begin
         n_bad++; $display("FAIL rd_err_set_wins: got %b expected 1", rd_err);
      end
      RoutSignals = '0;
      tick();
      err_clr = 1'b0;
      n_cmp++;
      if (rd_err !== 1'b0) begin
         n_bad++; $display("FAIL rd_err_clr: got %b expected 0", rd_err);
      end
   endtask

   task automatic test_rdw_and_async_clear();
      RinSignals = 16'h0080; RoutSignals = 16'h0080; BusMuxOut = 32'hA5A5_A5A5;
      #1;
      n_cmp++;
      if (BusMuxIn_R !== 32'h0) begin
         n_bad++; $display("FAIL rdw_old: got %h expected 00000000", BusMuxIn_R);
      end
      tick();
      RinSignals = '0; BusMuxOut = '0;
      #1;
      n_cmp++;
      if (BusMuxIn_R !== 32'hA5A5_A5A5) begin
         n_bad++; $display("FAIL rdw_new: got %h expected a5a5a5a5", BusMuxIn_R);
      end
      #2;
      clear = 1'b0;
      #1;
      n_cmp++;
      if (BusMuxIn_R !== 32'h0 || rout_valid !== 1'b1) begin
         n_bad++; $display("FAIL async_clear_r7: got %h valid %b expected 0 1", BusMuxIn_R, rout_valid);
      end
      RoutSignals = 16'h0020;
      #1;
      n_cmp++;
      if (BusMuxIn_R !== 32'h0) begin
         n_bad++; $display("FAIL async_clear_r5: got %h expected 00000000", BusMuxIn_R);
      end
      // Write presented while still in reset must be lost.
      RinSignals = 16'h0002; BusMuxOut = 32'h0000_0055;
      tick();
      RoutSignals = 16'h0002;
      #1;
      n_cmp++;
      if (BusMuxIn_R !== 32'h0) begin
         n_bad++; $display("FAIL write_in_reset: got %h expected 00000000", BusMuxIn_R);
      end
      clear = 1'b1;
      tick();
      RinSignals = '0;
      #1;
      n_cmp++;
      if (BusMuxIn_R !== 32'h0000_0055) begin
         n_bad++; $display("FAIL first_write_after_clear: got %h expected 00000055", BusMuxIn_R);
      end
      RoutSignals = '0;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_r0_baout();
      test_wr_multi();
      test_rd_multi();
      test_rdw_and_async_clear();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
